// File: rtl/lcd_timing_ctrl.sv
// Avalon-MM slave that sequences HD44780-style LCD bus cycles (setup, enable pulse, hold)
// for 8-bit or 4-bit interfaces, stalling the master until each transfer completes.
module lcd_timing_ctrl #(
  parameter int unsigned DATA_MODE = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxCyc = (MaxSp > HOLD_CYC) ? MaxSp : HOLD_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              nib_hi_q, nib_hi_d;
  logic              is_wr_q, is_wr_d;
  logic              rs_q, rs_d;
  logic              rw_q, rw_d;
  logic              e_q, e_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              drive;

  // RW is derived from the request type; the RW address bit is informational only.
  logic unused_addr;
  assign unused_addr = address[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      nib_hi_q <= 1'b0;
      is_wr_q  <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b1;
      e_q      <= 1'b0;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nib_hi_q <= nib_hi_d;
      is_wr_q  <= is_wr_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      e_q      <= e_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nib_hi_d = nib_hi_q;
    is_wr_d  = is_wr_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    e_d      = e_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (read || write) begin
          state_d  = StSetup;
          cnt_d    = CntW'(SETUP_CYC - 1);
          nib_hi_d = 1'b1;
          is_wr_d  = write;
          rs_d     = address[1];
          rw_d     = ~write;
          wdata_d  = writedata;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = CntW'(PULSE_CYC - 1);
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = CntW'(HOLD_CYC - 1);
          e_d     = 1'b0;
          // Sample the bus on the last enable-high cycle, nibble by nibble in 4-bit mode.
          if (!is_wr_q) begin
            if (DATA_MODE == 4) begin
              if (nib_hi_q) rdata_d[7:4] = LCD_data[7:4];
              else          rdata_d[3:0] = LCD_data[7:4];
            end else begin
              rdata_d = LCD_data;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (DATA_MODE == 4 && nib_hi_q) begin
            state_d  = StSetup;
            cnt_d    = CntW'(SETUP_CYC - 1);
            nib_hi_d = 1'b0;
          end else begin
            state_d = StDone;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign waitrequest = (read || write) && (state_q != StDone);
  assign readdata    = rdata_q;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;

  assign drive = is_wr_q && (state_q inside {StSetup, StPulse, StHold});

  if (DATA_MODE == 4) begin : g_bus4
    assign LCD_data[7:4] = drive ? (nib_hi_q ? wdata_q[7:4] : wdata_q[3:0]) : 4'bz;
    assign LCD_data[3:0] = 4'bz;
  end else begin : g_bus8
    assign LCD_data = drive ? wdata_q : 8'bz;
  end

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: 8-bit and 4-bit instances driven side by side with directed
// and random transfers, checked cycle by cycle against a phase-arithmetic reference model.
module tb_lcd_timing_ctrl;

  localparam int S   = 2;
  localparam int P   = 4;
  localparam int H   = 2;
  localparam int CYC = S + P + H;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       rd8, wr8, rd4, wr4;
  logic [7:0] rdata8, rdata4;
  logic       wait8, wait4, e8, e4, rs8, rs4, rw8, rw4;
  wire  [7:0] bus8;
  wire  [7:0] bus4;
  logic       tb_oe8, tb_oe4;
  logic [7:0] tb_val8;
  logic [3:0] tb_nib4;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_rd8, exp_rd4;

  always #5 clk = ~clk;

  // Bench-side LCD model: drives read data, pull-ups make an undriven bus read as all ones.
  assign bus8      = tb_oe8 ? tb_val8 : 8'hzz;
  assign bus4[7:4] = tb_oe4 ? tb_nib4 : 4'hz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu8 (bus8[i]);
    pullup pu4 (bus4[i]);
  end

  lcd_timing_ctrl #(.DATA_MODE(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut8 (
    .clk(clk), .reset(rst), .address(address), .read(rd8), .write(wr8),
    .writedata(writedata), .readdata(rdata8), .waitrequest(wait8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(bus8)
  );

  lcd_timing_ctrl #(.DATA_MODE(4), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut4 (
    .clk(clk), .reset(rst), .address(address), .read(rd4), .write(wr4),
    .writedata(writedata), .readdata(rdata4), .waitrequest(wait4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(bus4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enable is high in the pulse window of each of the n nibble phases after accept.
  function automatic logic e_exp(input int k, input int n);
    int p;
    if (k < 1 || k > n * CYC) return 1'b0;
    p = (k - 1) % CYC;
    return (p >= S) && (p < S + P);
  endfunction

  task automatic check_dut(input int n, input int k, input logic wr_op, input logic rs_exp,
                           input logic [7:0] wd, input logic [7:0] exp_rd,
                           input logic wt, input logic e, input logic rs, input logic rw,
                           input logic [7:0] bus, input logic [7:0] rd);
    int         t;
    int         nib;
    string      m;
    logic [7:0] exp_bus;
    t   = 1 + n * CYC;
    nib = (k - 1) / CYC;
    m   = $sformatf("m%0d k%0d", (n == 1) ? 8 : 4, k);
    check_eq({m, " e"}, 32'(e), 32'(e_exp(k, n)));
    check_eq({m, " wait"}, 32'(wt), 32'(k < t));
    check_eq({m, " rs"}, 32'(rs), 32'(rs_exp));
    check_eq({m, " rw"}, 32'(rw), 32'(!wr_op));
    if (wr_op) begin
      if (k < t) exp_bus = (n == 1) ? wd : {(nib == 0) ? wd[7:4] : wd[3:0], 4'hF};
      else       exp_bus = 8'hFF;
      check_eq({m, " bus"}, 32'(bus), 32'(exp_bus));
    end
    if (k == t) check_eq({m, " rdata"}, 32'(rd), 32'(exp_rd));
  endtask

  // Starts at a falling edge with both DUTs idle; cycle 0 is the accept cycle.
  task automatic run_xfer(input logic is_rd, input logic is_wr, input logic [1:0] adr,
                          input logic [7:0] wd, input logic [7:0] rv);
    int t8 = 1 + CYC;
    int t4 = 1 + 2 * CYC;
    address   = adr;
    writedata = wd;
    rd8 = is_rd; wr8 = is_wr; rd4 = is_rd; wr4 = is_wr;
    tb_oe8 = !is_wr; tb_val8 = rv;
    tb_oe4 = !is_wr; tb_nib4 = rv[7:4];
    if (!is_wr) begin
      exp_rd8 = rv;
      exp_rd4 = rv;
    end
    #1;
    check_eq("accept wait8", 32'(wait8), 32'd1);
    check_eq("accept wait4", 32'(wait4), 32'd1);
    for (int k = 1; k <= t4 + 1; k++) begin
      @(negedge clk);
      if (k == 1 + CYC) tb_nib4 = rv[3:0];
      check_dut(1, k, is_wr, adr[1], wd, exp_rd8, wait8, e8, rs8, rw8, bus8, rdata8);
      check_dut(2, k, is_wr, adr[1], wd, exp_rd4, wait4, e4, rs4, rw4, bus4, rdata4);
      if (k == t8) begin rd8 = 1'b0; wr8 = 1'b0; tb_oe8 = 1'b0; end
      if (k == t4) begin rd4 = 1'b0; wr4 = 1'b0; tb_oe4 = 1'b0; end
    end
  endtask

  task automatic reset_mid_xfer();
    address = 2'b10; writedata = 8'hA5;
    rd8 = 1'b0; wr8 = 1'b1; rd4 = 1'b0; wr4 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_rd8 = 8'h00;
    exp_rd4 = 8'h00;
    check_eq("rst e8", 32'(e8), 32'd0);
    check_eq("rst e4", 32'(e4), 32'd0);
    check_eq("rst rw8", 32'(rw8), 32'd1);
    check_eq("rst rs4", 32'(rs4), 32'd0);
    check_eq("rst bus8", 32'(bus8), 32'hFF);
    check_eq("rst bus4", 32'(bus4), 32'hFF);
    check_eq("rst rdata8", 32'(rdata8), 32'h00);
    check_eq("rst rdata4", 32'(rdata4), 32'h00);
    wr8 = 1'b0; wr4 = 1'b0;
    @(negedge clk);
    check_eq("rst hold e8", 32'(e8), 32'd0);
    rst = 1'b0;
    run_xfer(1'b0, 1'b1, 2'b10, 8'h01, 8'h00);
  endtask

  task automatic back_to_back();
    int   done1 = -1, done2 = -1, rise1 = -1, fall1 = -1, rise2 = -1;
    logic pe = 1'b0;
    rd4 = 1'b0; wr4 = 1'b0; rd8 = 1'b0; tb_oe8 = 1'b0;
    address = 2'b00; writedata = 8'hA5; wr8 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (e8 && !pe) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) begin
          rise2 = k;
          check_eq("b2b bus", 32'(bus8), 32'h0C);
          check_eq("b2b rw", 32'(rw8), 32'd0);
        end
      end
      if (!e8 && pe && fall1 < 0) fall1 = k;
      pe = e8;
      if (!wait8) begin
        if (done1 < 0) begin
          done1 = k; writedata = 8'h0C;
        end else if (done2 < 0) begin
          done2 = k; wr8 = 1'b0;
        end
      end
    end
    check_eq("b2b done1", 32'(done1), 32'(1 + CYC));
    check_eq("b2b done2", 32'(done2), 32'(3 + 2 * CYC));
    check_eq("b2b rise1", 32'(rise1), 32'(S + 1));
    check_eq("b2b gap", 32'(rise2 - fall1), 32'(H + 1 + 1 + S));
  endtask

  initial begin
    rst = 1'b1;
    address = 2'b00; writedata = 8'h00;
    rd8 = 1'b0; wr8 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    tb_oe8 = 1'b0; tb_oe4 = 1'b0; tb_val8 = 8'h00; tb_nib4 = 4'h0;
    exp_rd8 = 8'h00; exp_rd4 = 8'h00;
    @(negedge clk);
    check_eq("por e8", 32'(e8), 32'd0);
    check_eq("por rw8", 32'(rw8), 32'd1);
    check_eq("por rs8", 32'(rs8), 32'd0);
    check_eq("por rw4", 32'(rw4), 32'd1);
    check_eq("por rdata8", 32'(rdata8), 32'h00);
    check_eq("por bus8", 32'(bus8), 32'hFF);
    check_eq("por wait8", 32'(wait8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1'b0, 1'b1, 2'b10, 8'hA5, 8'h00);
    run_xfer(1'b1, 1'b0, 2'b01, 8'h00, 8'h3C);
    run_xfer(1'b0, 1'b1, 2'b10, 8'h5E, 8'h00);
    run_xfer(1'b1, 1'b1, 2'b00, 8'h38, 8'h00);

    for (int i = 0; i < 20; i++) begin
      int         op;
      logic [1:0] adr;
      logic [7:0] wd, rv;
      op  = $urandom_range(0, 2);
      adr = 2'($urandom_range(0, 3));
      wd  = 8'($urandom);
      rv  = 8'($urandom);
      run_xfer(op != 1, op != 0, adr, wd, rv);
    end

    reset_mid_xfer();
    back_to_back();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_timing_ctrl.md
LCD_TIMING_CTRL -- requirements
Module: lcd_timing_ctrl

Interface
REQ-001 Parameter DATA_MODE, default 8, meaning LCD bus width; legal values 8 or 4.
REQ-002 Parameter SETUP_CYC, default 2, meaning clk cycles RS/RW/data are valid before LCD_E rises; minimum 1.
REQ-003 Parameter PULSE_CYC, default 12, meaning clk cycles LCD_E is high per nibble/byte; minimum 1.
REQ-004 Parameter HOLD_CYC, default 2, meaning clk cycles RS/RW/data are held after LCD_E falls; minimum 1.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  2  bit0 = RW (1 read), bit1 = RS (1 data, 0 instruction).
REQ-008 read  in  1  Avalon-MM read request.
REQ-009 write  in  1  Avalon-MM write request.
REQ-010 writedata  in  8  byte to write to LCD.
REQ-011 readdata  out  8  byte read from LCD, registered.
REQ-012 waitrequest  out  1  Avalon stall; master holds request while high.
REQ-013 LCD_E  out  1  LCD enable strobe, registered.
REQ-014 LCD_RS  out  1  LCD register select, registered.
REQ-015 LCD_RW  out  1  LCD read/write, registered.
REQ-016 LCD_data  inout  8  LCD data bus; in 4-bit mode only [7:4] used, [3:0] permanently high-Z.

Function
REQ-017 States: IDLE, SETUP, PULSE, HOLD, DONE; one down-counter of width clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC))+1 times phases.
REQ-018 IDLE: on read|write, latch op (write wins if both high), RS=address[1], RW=~write, writedata; go SETUP; nibble index = high.
REQ-019 SETUP lasts exactly SETUP_CYC cycles, LCD_E=0; then PULSE.
REQ-020 PULSE lasts exactly PULSE_CYC cycles, LCD_E=1; on read, bus sampled in the final PULSE cycle into readdata (8-bit: [7:0]; 4-bit high nibble: [7:4], low nibble: [3:0]).
REQ-021 HOLD lasts exactly HOLD_CYC cycles, LCD_E=0; then DONE, except DATA_MODE=4 with high nibble done -> SETUP for low nibble.
REQ-022 DONE lasts one cycle, then IDLE; a request present in that IDLE cycle starts a new transfer (one IDLE cycle minimum between transfers).
REQ-023 waitrequest = (read|write) & (state != DONE), combinational; low for exactly one cycle per transfer.
REQ-024 Write data driven onto LCD_data only in SETUP/PULSE/HOLD of a write op; 8-bit drives writedata[7:0]; 4-bit drives [7:4] = high nibble then low nibble; high-Z otherwise, including IDLE and DONE.
REQ-025 LCD_RS/LCD_RW hold latched values from SETUP through DONE and keep them in IDLE until the next accept.
REQ-026 readdata updates only on read ops; writes leave it unchanged.
REQ-027 Latency, accept cycle to DONE cycle: 1+N*(SETUP_CYC+PULSE_CYC+HOLD_CYC), N=1 (8-bit) or 2 (4-bit).

Reset
REQ-028 reset asserted (any time, incl. mid-transfer): state=IDLE, LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data high-Z, readdata=8'h00, counter=0, immediately without clk.
REQ-029 After reset release, the first rising edge with read|write accepts a transfer normally; an aborted transfer is never resumed.

Verification (SETUP_CYC=2, PULSE_CYC=4, HOLD_CYC=2; accept cycle = 0)
REQ-030 8-bit write, address=2'b10, writedata=8'hA5 -> RS=1, RW=0, LCD_data=8'hA5 cycles 1-8, LCD_E=1 cycles 3-6 only, waitrequest=1 cycles 0-8, 0 at cycle 9, bus high-Z at 9.
REQ-031 8-bit read, address=2'b01, bench drives 8'h3C -> RW=1, bus never driven by DUT, readdata=8'h3C at cycle 9 with waitrequest=0.
REQ-032 DATA_MODE=4 write 8'h5E, address=2'b10 -> LCD_data[7:4]=4'h5 with E high cycles 3-6, 4'hE with E high cycles 11-14, [3:0] high-Z throughout, waitrequest=0 at cycle 17.
REQ-033 reset pulsed at cycle 4 of an 8-bit write -> LCD_E=0 and bus high-Z during reset, RW=1, no DONE; next write 8'h01 completes with waitrequest=0 at cycle 9 after its accept.
REQ-034 read=write=1, address=2'b00, writedata=8'h38 -> treated as write: RW=0, bus=8'h38, readdata unchanged.
REQ-035 write held high through DONE with new writedata=8'h0C -> IDLE one cycle, second transfer accepted immediately after, E pulses separated by exactly HOLD_CYC+1+1+SETUP_CYC cycles low.
